multicycle_ctrl: RTL

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: control FSM for a multicycle RV32I-subset datapath.
// Optional feature: define MULTICYCLE_JALR_EN to add the JALR state and
// accept op 1100111; without it that opcode is reported as Illegal.
// Outputs are decoded from the state register in the same cycle because
// IRWrite/PCWrite in FETCH, PCWrite in BRANCH and Illegal in DECODE depend
// on same-cycle inputs (MemReady, Zero, op). Reset forces FETCH values.
module multicycle_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       AdrSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [3:0] ALUControl,
    output logic [2:0] ImmSrc,
    output logic       Illegal
);

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_AUI  = 7'b0010111;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_SLT = 4'b0101;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECUTER,
        S_EXECUTEI,
        S_ALUWB,
        S_JAL,
        S_BRANCH
`ifdef MULTICYCLE_JALR_EN
        , S_JALR
`endif
    } state_t;

    state_t     state_q, state_d;
    state_t     dec_state;
    logic       op_legal;
    logic [3:0] alu_fn;

    // Opcode dispatch out of DECODE; unknown opcodes fall back to FETCH.
    always_comb begin
        dec_state = S_FETCH;
        op_legal  = 1'b1;
        case (op)
            OP_LW, OP_SW: dec_state = S_MEMADR;
            OP_R:         dec_state = S_EXECUTER;
            OP_I:         dec_state = S_EXECUTEI;
            OP_JAL:       dec_state = S_JAL;
            OP_BR:        dec_state = S_BRANCH;
`ifdef MULTICYCLE_JALR_EN
            OP_JALR:      dec_state = S_JALR;
`endif
            default:      op_legal  = 1'b0;
        endcase
    end

    // ALU operation for the execute states from funct3 (sub only for R-type).
    always_comb begin
        case (funct3)
            3'b000:  alu_fn = (op == OP_R && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b010:  alu_fn = ALU_SLT;
            3'b110:  alu_fn = ALU_OR;
            3'b111:  alu_fn = ALU_AND;
            default: alu_fn = ALU_ADD;
        endcase
    end

    // Immediate format, independent of state.
    always_comb begin
        case (op)
            OP_LW, OP_I, OP_JALR: ImmSrc = 3'b000;
            OP_SW:                ImmSrc = 3'b001;
            OP_BR:                ImmSrc = 3'b010;
            OP_JAL:               ImmSrc = 3'b011;
            OP_LUI, OP_AUI:       ImmSrc = 3'b100;
            default:              ImmSrc = 3'b000;
        endcase
    end

    // Next-state logic; memory states wait on MemReady.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (MemReady) state_d = S_DECODE;
            S_DECODE:   state_d = dec_state;
            S_MEMADR:   state_d = (op == OP_LW) ? S_MEMREAD :
                                  (op == OP_SW) ? S_MEMWRITE : S_FETCH;
            S_MEMREAD:  if (MemReady) state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: if (MemReady) state_d = S_FETCH;
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            S_BRANCH:   state_d = S_FETCH;
`ifdef MULTICYCLE_JALR_EN
            S_JALR:     state_d = S_ALUWB;
`endif
            default:    state_d = S_FETCH;
        endcase
    end

    // State register with synchronous reset to FETCH.
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    // Per-state output decode; reset overrides to FETCH selects, enables off.
    always_comb begin
        PCWrite    = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        MemWrite   = 1'b0;
        AdrSrc     = 1'b0;
        Illegal    = 1'b0;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        ALUControl = ALU_ADD;
        if (reset) begin
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
        end else begin
            case (state_q)
                S_FETCH: begin
                    ALUSrcB   = 2'b10;
                    ResultSrc = 2'b10;
                    IRWrite   = MemReady;
                    PCWrite   = MemReady;
                end
                S_DECODE: begin
                    ALUSrcA = 2'b01;
                    ALUSrcB = 2'b01;
                    Illegal = ~op_legal;
                end
                S_MEMADR: begin
                    ALUSrcA = 2'b10;
                    ALUSrcB = 2'b01;
                end
                S_MEMREAD:  AdrSrc = 1'b1;
                S_MEMWB: begin
                    ResultSrc = 2'b01;
                    RegWrite  = 1'b1;
                end
                S_MEMWRITE: begin
                    AdrSrc   = 1'b1;
                    MemWrite = 1'b1;
                end
                S_EXECUTER: begin
                    ALUSrcA    = 2'b10;
                    ALUControl = alu_fn;
                end
                S_EXECUTEI: begin
                    ALUSrcA    = 2'b10;
                    ALUSrcB    = 2'b01;
                    ALUControl = alu_fn;
                end
                S_ALUWB:    RegWrite = 1'b1;
                S_JAL: begin
                    ALUSrcA = 2'b01;
                    ALUSrcB = 2'b10;
                    PCWrite = 1'b1;
                end
                S_BRANCH: begin
                    ALUSrcA    = 2'b10;
                    ALUControl = ALU_SUB;
                    PCWrite    = (funct3 == 3'b000) ? Zero :
                                 (funct3 == 3'b001) ? ~Zero : 1'b0;
                end
`ifdef MULTICYCLE_JALR_EN
                S_JALR: begin
                    ALUSrcA = 2'b10;
                    ALUSrcB = 2'b01;
                    PCWrite = 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule
